// File: rtl/in_fifo_pack_pkg.sv
// Shared decoder constants and the input-buffer FSM encoding.
package in_fifo_pack_pkg;

  localparam int NB              = 16;
  localparam int HDDW            = 32;
  localparam int MAXINCYCLES     = 256;
  localparam int ADDRESSWIDTH    = 4;
  localparam int LANEBITS        = 4;
  localparam int CYCLECOUNTWIDTH = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } infifo_state_e;

endpackage

// File: rtl/in_fifo_pack_ram.sv
// One lane of the input buffer: simple dual-port RAM, write port and registered read port.
module simpledualportram_syncread_ne #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] rd_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (re) begin
      rd_d = mem[ra];
    end
  end

  // Output register resets to zero and holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd = rd_q;

endmodule

// File: rtl/in_fifo_pack.sv
// Decoder input buffer: packs a HDDW-bit word stream into NB lane RAMs and exposes full rows.
// Optional INFIFO_OVERFLOW_EN adds a sticky overflow_err output.
module in_fifo_pack
  import in_fifo_pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HDDW-1:0]         HD_in,
  input  logic                    datavalid,
  output logic                    in_ready,
  input  logic [ADDRESSWIDTH-1:0] RA,
  input  logic                    rd_en,
  output logic [NB*HDDW-1:0]      RDDOUT_nb,
  output logic                    frame_ready,
`ifdef INFIFO_OVERFLOW_EN
  output logic                    overflow_err,
`endif
  input  logic                    load_done
);

  if (MAXINCYCLES % NB != 0) begin : g_cfg_mult_err
    $error("in_fifo_pack: MAXINCYCLES must be a multiple of NB");
  end
  if (MAXINCYCLES / NB != 2**ADDRESSWIDTH) begin : g_cfg_rows_err
    $error("in_fifo_pack: MAXINCYCLES/NB must equal 2**ADDRESSWIDTH");
  end

  infifo_state_e              state_q, state_d;
  logic [CYCLECOUNTWIDTH-1:0] cyclecount_q, cyclecount_d;
  logic                       wr_en;
  logic                       rd_go;
  logic [LANEBITS-1:0]        wr_lane;
  logic [ADDRESSWIDTH-1:0]    wr_row;

  assign wr_lane = cyclecount_q[LANEBITS-1:0];
  assign wr_row  = cyclecount_q[LANEBITS +: ADDRESSWIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      cyclecount_q <= '0;
    end else begin
      state_q      <= state_d;
      cyclecount_q <= cyclecount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cyclecount_d = cyclecount_q;
    case (state_q)
      FILL: begin
        if (datavalid) begin
          if (cyclecount_q == CYCLECOUNTWIDTH'(MAXINCYCLES - 1)) begin
            cyclecount_d = '0;
            state_d      = FULL;
          end else begin
            cyclecount_d = cyclecount_q + CYCLECOUNTWIDTH'(1);
          end
        end
      end
      FULL: begin
        if (load_done) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake and RAM controls decode straight from the state register.
  always_comb begin
    in_ready    = (state_q == FILL);
    frame_ready = (state_q == FULL);
    wr_en       = datavalid & (state_q == FILL);
    rd_go       = rd_en & (state_q == FULL);
  end

`ifdef INFIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (datavalid & ~in_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_err = overflow_q;
`endif

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic lane_we;

    assign lane_we = wr_en & (wr_lane == LANEBITS'(gi));

    simpledualportram_syncread_ne #(
      .DW(HDDW),
      .AW(ADDRESSWIDTH)
    ) u_ram (
      .clk(clk),
      .rst(rst),
      .we (lane_we),
      .wa (wr_row),
      .wd (HD_in),
      .re (rd_go),
      .ra (RA),
      .rd (RDDOUT_nb[gi*HDDW +: HDDW])
    );
  end

endmodule

// File: tb/tb_in_fifo_pack.sv
// Directed self-checking bench for in_fifo_pack (works with or without INFIFO_OVERFLOW_EN).
module tb_in_fifo_pack;
  import in_fifo_pack_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [HDDW-1:0]         HD_in = '0;
  logic                    datavalid = 1'b0;
  logic                    in_ready;
  logic [ADDRESSWIDTH-1:0] RA = '0;
  logic                    rd_en = 1'b0;
  logic [NB*HDDW-1:0]      RDDOUT_nb;
  logic                    frame_ready;
  logic                    load_done = 1'b0;
`ifdef INFIFO_OVERFLOW_EN
  logic                    overflow_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  in_fifo_pack dut (
    .clk        (clk),
    .rst        (rst),
    .HD_in      (HD_in),
    .datavalid  (datavalid),
    .in_ready   (in_ready),
    .RA         (RA),
    .rd_en      (rd_en),
    .RDDOUT_nb  (RDDOUT_nb),
    .frame_ready(frame_ready),
`ifdef INFIFO_OVERFLOW_EN
    .overflow_err(overflow_err),
`endif
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NB*HDDW-1:0] obs,
                       input logic [NB*HDDW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB*HDDW-1:0] row_exp(input int base);
    logic [NB*HDDW-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) v[k*HDDW +: HDDW] = HDDW'(base + k);
    return v;
  endfunction

  task automatic read_row(input int row);
    RA = ADDRESSWIDTH'(row);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    int acc;
    int c;
    logic [NB*HDDW-1:0] held;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_rddout", RDDOUT_nb, 0);
`ifdef INFIFO_OVERFLOW_EN
    check("rst_overflow", overflow_err, 0);
`endif
    step();
    rst = 1'b1;
    step();

    // 1: back-to-back frame, HD_in = n
    for (int n = 0; n < MAXINCYCLES; n++) begin
      datavalid = 1'b1;
      HD_in = HDDW'(n);
      step();
      if (n == MAXINCYCLES - 2) check("t1_not_ready_before_last", frame_ready, 0);
    end
    datavalid = 1'b0;
    check("t1_frame_ready", frame_ready, 1);
    check("t1_in_ready_low", in_ready, 0);
    read_row(3);
    check("t1_row3", RDDOUT_nb, row_exp(48));

    // 3: overflow writes while FULL are dropped
    for (int i = 0; i < 10; i++) begin
      datavalid = 1'b1;
      HD_in = 32'hFFFF_FFFF;
      step();
    end
    datavalid = 1'b0;
    check("t3_still_full", frame_ready, 1);
    read_row(3);
    check("t3_row3_unchanged", RDDOUT_nb, row_exp(48));
    read_row(0);
    check("t3_row0_unchanged", RDDOUT_nb, row_exp(0));
`ifdef INFIFO_OVERFLOW_EN
    check("t3_overflow_set", overflow_err, 1);
`endif

    // 4: read and release in the same cycle
    RA = 4'd15;
    rd_en = 1'b1;
    load_done = 1'b1;
    step();
    rd_en = 1'b0;
    load_done = 1'b0;
    check("t4_row15", RDDOUT_nb, row_exp(240));
    check("t4_frame_ready_low", frame_ready, 0);
    check("t4_in_ready_high", in_ready, 1);

    // 2: gapped frame (idle 1 in 3 cycles), with 6: FILL-time rd_en/load_done ignored
    acc = 0;
    c = 0;
    while (acc < MAXINCYCLES) begin
      if (acc == 100 && c % 3 == 0) begin
        held = RDDOUT_nb;
        datavalid = 1'b0;
        rd_en = 1'b1;
        RA = 4'd0;
        load_done = 1'b1;
        step();
        rd_en = 1'b0;
        load_done = 1'b0;
        check("t6_rddout_holds", RDDOUT_nb, held);
        check("t6_in_ready", in_ready, 1);
        check("t6_frame_ready", frame_ready, 0);
        c++;
      end
      datavalid = (c % 3 != 2);
      HD_in = HDDW'(acc);
      step();
      if (datavalid) acc++;
      c++;
      if (acc == MAXINCYCLES - 1 && datavalid)
        check("t2_not_ready_after_255", frame_ready, 0);
    end
    datavalid = 1'b0;
    check("t2_frame_ready", frame_ready, 1);
    read_row(3);
    check("t2_row3", RDDOUT_nb, row_exp(48));
    read_row(10);
    check("t2_row10", RDDOUT_nb, row_exp(160));

    // 5: abort a partial frame with reset, then load a fresh frame
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      datavalid = 1'b1;
      HD_in = HDDW'(7000 + n);
      step();
    end
    datavalid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_rddout", RDDOUT_nb, 0);
    check("t5_rst_in_ready", in_ready, 1);
`ifdef INFIFO_OVERFLOW_EN
    check("t5_overflow_cleared", overflow_err, 0);
`endif
    step();
    rst = 1'b1;
    step();
    for (int n = 0; n < MAXINCYCLES; n++) begin
      datavalid = 1'b1;
      HD_in = HDDW'(1000 + n);
      step();
      if (n == MAXINCYCLES - 2) check("t5_not_ready_before_last", frame_ready, 0);
    end
    datavalid = 1'b0;
    check("t5_frame_ready", frame_ready, 1);
    read_row(0);
    check("t5_row0", RDDOUT_nb, row_exp(1000));
    read_row(6);
    check("t5_row6_no_residue", RDDOUT_nb, row_exp(1096));
    read_row(15);
    check("t5_row15", RDDOUT_nb, row_exp(1240));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
